// File: rtl/sramlike_arbiter_pkg.sv
// Shared definitions for the SRAM-like N-to-1 arbiter: size encodings,
// arbitration mode selectors and the grant-lock FSM state type.
package sramlike_arbiter_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/sramlike_owner_fifo.sv
// In-order owner FIFO: remembers which master each accepted request belongs
// to, so slave responses can be routed back without any added latency.
module sramlike_owner_fifo #(
    parameter int W     = 1,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // NOTE: storage carries no reset; entries are only read below count_q,
    // so stale contents are never observed and the array maps to plain RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= push_data;
    end

    // NOTE: every next-state variable gets its default first, so no path
    // through this block can leave a value unassigned and infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
    end

    // NOTE: state registers use non-blocking assignment so all flops sample
    // their inputs at the same edge regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem[rd_ptr_q];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/sramlike_arbiter.sv
// N-master to 1-slave SRAM-like bus arbiter with pipelined in-order responses;
// the grant is held across a stalled address handshake, responses follow an owner FIFO.
module sramlike_arbiter
    import sramlike_arbiter_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 4,
    parameter int ARB_MODE  = ARB_FIXED
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [N_MASTERS-1:0]           m_req,
    input  logic [N_MASTERS-1:0]           m_wr,
    input  logic [2*N_MASTERS-1:0]         m_size,
    input  logic [ADDR_W*N_MASTERS-1:0]    m_addr,
    input  logic [DATA_W*N_MASTERS-1:0]    m_wdata,
    output logic [N_MASTERS-1:0]           m_addr_ok,
    output logic [N_MASTERS-1:0]           m_data_ok,
    output logic [DATA_W-1:0]              m_rdata,
    output logic                           s_req,
    output logic                           s_wr,
    output logic [1:0]                     s_size,
    output logic [ADDR_W-1:0]              s_addr,
    output logic [DATA_W-1:0]              s_wdata,
    input  logic                           s_addr_ok,
    input  logic                           s_data_ok,
    input  logic [DATA_W-1:0]              s_rdata,
    output logic [$clog2(MAX_OUTST+1)-1:0] outst_cnt,
    output logic                           err
);

    localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             err_q, err_d;
    logic [IDX_W-1:0] arb_grant, cur_grant, fifo_head;
    logic             arb_valid, cur_valid;
    logic             accept, pop, fifo_full, fifo_empty;

    // Search order starts at rr_ptr in round-robin mode, at index 0 otherwise.
    always_comb begin
        arb_grant = '0;
        arb_valid = 1'b0;
        for (int k = 0; k < N_MASTERS; k++) begin
            logic [IDX_W-1:0] idx;
            if (ARB_MODE == ARB_RR) idx = IDX_W'((int'(rr_ptr_q) + k) % N_MASTERS);
            else                    idx = IDX_W'(k);
            if (!arb_valid && m_req[idx]) begin
                arb_valid = 1'b1;
                arb_grant = idx;
            end
        end
    end

    assign cur_grant = (state_q == LOCKED) ? grant_q : arb_grant;
    assign cur_valid = (state_q == LOCKED) ? m_req[grant_q] : arb_valid;

    assign s_req   = resetn & cur_valid & ~fifo_full;
    assign accept  = s_req & s_addr_ok;
    assign pop     = s_data_ok & ~fifo_empty;

    assign s_wr    = m_wr[cur_grant];
    assign s_size  = m_size[2*int'(cur_grant) +: 2];
    assign s_addr  = m_addr[ADDR_W*int'(cur_grant) +: ADDR_W];
    assign s_wdata = m_wdata[DATA_W*int'(cur_grant) +: DATA_W];

    assign m_addr_ok = accept ? (N_MASTERS'(1) << cur_grant) : '0;
    assign m_data_ok = pop    ? (N_MASTERS'(1) << fifo_head) : '0;
    assign m_rdata   = s_rdata;
    assign err       = err_q;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        err_d    = err_q | (s_data_ok & fifo_empty);
        case (state_q)
            IDLE: begin
                if (s_req && !s_addr_ok) begin
                    state_d = LOCKED;
                    grant_d = arb_grant;
                end
            end
            LOCKED:  if (accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (ARB_MODE == ARB_RR && accept)
            rr_ptr_d = (int'(cur_grant) == N_MASTERS-1) ? '0 : cur_grant + 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
        end
    end

    sramlike_owner_fifo #(
        .W     (IDX_W),
        .DEPTH (MAX_OUTST)
    ) u_owner_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (accept),
        .push_data (cur_grant),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (outst_cnt)
    );

endmodule

// File: tb/tb_sramlike_arbiter.sv
// Bench for sramlike_arbiter: a 2-master fixed-priority instance and a 4-master
// round-robin instance, directed scenarios plus random traffic against a queue model.
module tb_sramlike_arbiter;
    import sramlike_arbiter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         resetn;
    logic [3:0]   m_req, m_wr;
    logic [7:0]   m_size;
    logic [127:0] m_addr, m_wdata;
    logic [1:0]   s_aok, s_dok;
    logic [31:0]  s_rdata;

    logic [1:0]  f_aok, f_dok, f_ssize, r_ssize;
    logic [3:0]  r_aok, r_dok;
    logic [31:0] f_rdata, r_rdata, f_saddr, r_saddr, f_swdata, r_swdata;
    logic        f_sreq, r_sreq, f_swr, r_swr, f_err, r_err;
    logic [2:0]  f_cnt, r_cnt;

    sramlike_arbiter #(.N_MASTERS(2), .MAX_OUTST(4), .ARB_MODE(ARB_FIXED)) dut_fx (
        .clk(clk), .resetn(resetn), .m_req(m_req[1:0]), .m_wr(m_wr[1:0]),
        .m_size(m_size[3:0]), .m_addr(m_addr[63:0]), .m_wdata(m_wdata[63:0]),
        .m_addr_ok(f_aok), .m_data_ok(f_dok), .m_rdata(f_rdata),
        .s_req(f_sreq), .s_wr(f_swr), .s_size(f_ssize), .s_addr(f_saddr), .s_wdata(f_swdata),
        .s_addr_ok(s_aok[0]), .s_data_ok(s_dok[0]), .s_rdata(s_rdata),
        .outst_cnt(f_cnt), .err(f_err));

    sramlike_arbiter #(.N_MASTERS(4), .MAX_OUTST(4), .ARB_MODE(ARB_RR)) dut_rr (
        .clk(clk), .resetn(resetn), .m_req(m_req), .m_wr(m_wr),
        .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(r_aok), .m_data_ok(r_dok), .m_rdata(r_rdata),
        .s_req(r_sreq), .s_wr(r_swr), .s_size(r_ssize), .s_addr(r_saddr), .s_wdata(r_swdata),
        .s_addr_ok(s_aok[1]), .s_data_ok(s_dok[1]), .s_rdata(s_rdata),
        .outst_cnt(r_cnt), .err(r_err));

    // Uniform views of both instances, index 0 = fixed, 1 = round-robin.
    logic [3:0]  o_aok [2], o_dok [2];
    logic        o_sreq [2], o_swr [2], o_err [2];
    logic [1:0]  o_ssize [2];
    logic [31:0] o_saddr [2], o_swdata [2], o_rdata [2];
    logic [2:0]  o_cnt [2];
    assign o_aok[0] = {2'b00, f_aok};  assign o_aok[1] = r_aok;
    assign o_dok[0] = {2'b00, f_dok};  assign o_dok[1] = r_dok;
    assign o_sreq[0] = f_sreq;         assign o_sreq[1] = r_sreq;
    assign o_swr[0] = f_swr;           assign o_swr[1] = r_swr;
    assign o_err[0] = f_err;           assign o_err[1] = r_err;
    assign o_ssize[0] = f_ssize;       assign o_ssize[1] = r_ssize;
    assign o_saddr[0] = f_saddr;       assign o_saddr[1] = r_saddr;
    assign o_swdata[0] = f_swdata;     assign o_swdata[1] = r_swdata;
    assign o_rdata[0] = f_rdata;       assign o_rdata[1] = r_rdata;
    assign o_cnt[0] = f_cnt;           assign o_cnt[1] = r_cnt;

    int checks = 0;
    int failures = 0;

    // Reference model: owner list as a shifting array, plus pending-grant and pointer.
    int own [2][4];
    int ocnt [2];
    bit lck [2];
    int lg [2];
    int ptr [2];
    bit merr [2];

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            ocnt[d] = 0; lck[d] = 0; lg[d] = 0; ptr[d] = 0; merr[d] = 0;
        end
    endtask

    task automatic model_expect(input int d, output int g, output bit sreq,
                                output logic [3:0] aok, output logic [3:0] dok);
        int nm;
        bit valid;
        logic [3:0] reqv;
        nm   = (d == 1) ? 4 : 2;
        reqv = (d == 1) ? m_req : {2'b00, m_req[1:0]};
        if (lck[d]) begin
            g = lg[d];
            valid = reqv[g];
        end else begin
            g = -1;
            for (int k = 0; k < nm; k++)
                if (g < 0 && reqv[(ptr[d] + k) % nm]) g = (ptr[d] + k) % nm;
            valid = (g >= 0);
            if (g < 0) g = 0;
        end
        sreq = resetn && valid && (ocnt[d] < 4);
        aok  = (sreq && s_aok[d]) ? (4'b0001 << g) : 4'b0000;
        dok  = (s_dok[d] && ocnt[d] > 0) ? (4'b0001 << own[d][0]) : 4'b0000;
    endtask

    task automatic model_commit();
        int g;
        bit sr;
        logic [3:0] ao, dk;
        for (int d = 0; d < 2; d++) begin
            model_expect(d, g, sr, ao, dk);
            if (s_dok[d]) begin
                if (ocnt[d] > 0) begin
                    for (int k = 0; k < 3; k++) own[d][k] = own[d][k+1];
                    ocnt[d]--;
                end else merr[d] = 1'b1;
            end
            if (ao != 4'b0000) begin
                own[d][ocnt[d]] = g;
                ocnt[d]++;
                lck[d] = 1'b0;
                if (d == 1) ptr[d] = (g + 1) % 4;
            end else if (sr) begin
                lck[d] = 1'b1;
                lg[d] = g;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic idle_inputs();
        m_req = '0; m_wr = '0; m_size = '0; s_aok = '0; s_dok = '0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle_inputs();
        model_clear();
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        model_clear();
        m_req = 4'hf; s_aok = 2'b11; s_dok = 2'b11;
        #3;
        checks++; if ({f_sreq, r_sreq} !== 2'b00) begin failures++; $display("FAIL reset_sreq: got %b want 00", {f_sreq, r_sreq}); end
        checks++; if ({f_aok, r_aok} !== 6'b0) begin failures++; $display("FAIL reset_addr_ok: got %b want 0", {f_aok, r_aok}); end
        checks++; if ({f_dok, r_dok} !== 6'b0) begin failures++; $display("FAIL reset_data_ok: got %b want 0", {f_dok, r_dok}); end
        checks++; if ({f_cnt, r_cnt} !== 6'b0) begin failures++; $display("FAIL reset_cnt: got %b want 0", {f_cnt, r_cnt}); end
        @(posedge clk); #1;
        checks++; if ({f_err, r_err} !== 2'b00) begin failures++; $display("FAIL reset_err: got %b want 00", {f_err, r_err}); end
        idle_inputs();
        #1 resetn = 1'b1;
    endtask

    task automatic test_fixed_priority();
        do_reset();
        m_req = 4'b0011; s_aok = 2'b01;
        m_addr[31:0] = 32'h0000_0400; m_addr[63:32] = 32'h0000_0800;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (f_aok !== 2'b01) begin failures++; $display("FAIL fixed_grant[%0d]: got %b want 01", i, f_aok); end
            checks++; if (f_saddr !== 32'h0000_0400) begin failures++; $display("FAIL fixed_addr[%0d]: got %h want 00000400", i, f_saddr); end
            tick();
        end
        m_req = '0; s_aok = '0; s_dok = 2'b01;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (f_dok !== 2'b01) begin failures++; $display("FAIL fixed_resp[%0d]: got %b want 01", i, f_dok); end
            tick();
        end
        s_dok = '0;
    endtask

    task automatic test_round_robin();
        for (int p = 0; p < 2; p++) begin
            int want, prev;
            do_reset();
            m_req = (p == 0) ? 4'b0011 : 4'b1010;
            s_aok = 2'b10;
            prev = 0;
            for (int i = 0; i < 4; i++) begin
                want = (p == 0) ? (i % 2) : ((i % 2 == 0) ? 1 : 3);
                s_dok[1] = (i > 0);
                @(negedge clk);
                checks++; if (r_aok !== (4'b0001 << want)) begin failures++; $display("FAIL rr_grant[%0d][%0d]: got %b want master %0d", p, i, r_aok, want); end
                if (i > 0) begin
                    checks++; if (r_dok !== (4'b0001 << prev)) begin failures++; $display("FAIL rr_resp[%0d][%0d]: got %b want master %0d", p, i, r_dok, prev); end
                end
                prev = want;
                tick();
            end
        end
        idle_inputs();
    endtask

    task automatic test_lock();
        do_reset();
        m_addr[31:0] = 32'h0000_1000; m_addr[63:32] = 32'h1fc0_0000;
        m_req = 4'b0010; s_aok = 2'b00;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) m_req = 4'b0011;
            @(negedge clk);
            checks++; if ({f_sreq, f_aok, f_saddr} !== {1'b1, 2'b00, 32'h1fc0_0000}) begin
                failures++; $display("FAIL lock_hold[%0d]: got req=%b ok=%b addr=%h want 1 00 1fc00000", i, f_sreq, f_aok, f_saddr);
            end
            tick();
        end
        s_aok = 2'b01;
        @(negedge clk);
        checks++; if ({f_aok, f_saddr} !== {2'b10, 32'h1fc0_0000}) begin failures++; $display("FAIL lock_accept: got ok=%b addr=%h want 10 1fc00000", f_aok, f_saddr); end
        tick();
        @(negedge clk);
        checks++; if ({f_aok, f_saddr} !== {2'b01, 32'h0000_1000}) begin failures++; $display("FAIL lock_next: got ok=%b addr=%h want 01 00001000", f_aok, f_saddr); end
        tick();
        idle_inputs();
    endtask

    task automatic test_full();
        do_reset();
        m_req = 4'b0001; s_aok = 2'b01;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (f_aok !== 2'b01) begin failures++; $display("FAIL full_fill[%0d]: got %b want 01", i, f_aok); end
            tick();
        end
        m_req = 4'b0011;
        @(negedge clk);
        checks++; if ({f_cnt, f_sreq, f_aok} !== {3'd4, 1'b0, 2'b00}) begin failures++; $display("FAIL full_block: got cnt=%0d req=%b ok=%b want 4 0 00", f_cnt, f_sreq, f_aok); end
        tick();
        s_dok = 2'b01;
        @(negedge clk);
        checks++; if ({f_dok, f_sreq} !== {2'b01, 1'b0}) begin failures++; $display("FAIL full_pop: got dok=%b req=%b want 01 0", f_dok, f_sreq); end
        tick();
        s_dok = 2'b00;
        @(negedge clk);
        checks++; if ({f_cnt, f_sreq, f_aok} !== {3'd3, 1'b1, 2'b01}) begin failures++; $display("FAIL full_reopen: got cnt=%0d req=%b ok=%b want 3 1 01", f_cnt, f_sreq, f_aok); end
        tick();
        @(negedge clk);
        checks++; if ({f_cnt, f_sreq} !== {3'd4, 1'b0}) begin failures++; $display("FAIL full_refill: got cnt=%0d req=%b want 4 0", f_cnt, f_sreq); end
        idle_inputs();
    endtask

    task automatic test_in_order();
        do_reset();
        s_aok = 2'b01;
        for (int i = 0; i < 3; i++) begin
            m_req = (i == 1) ? 4'b0010 : 4'b0001;
            @(negedge clk);
            checks++; if (f_aok !== ((i == 1) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL order_accept[%0d]: got %b", i, f_aok); end
            tick();
        end
        m_req = '0; s_aok = '0; s_dok = 2'b01;
        for (int i = 0; i < 3; i++) begin
            s_rdata = 32'(i + 1) * 32'h11;
            @(negedge clk);
            checks++; if (f_dok !== ((i == 1) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL order_resp[%0d]: got %b", i, f_dok); end
            checks++; if (f_rdata !== 32'(i + 1) * 32'h11) begin failures++; $display("FAIL order_rdata[%0d]: got %h", i, f_rdata); end
            tick();
        end
        s_dok = '0;
        @(negedge clk);
        checks++; if (f_cnt !== 3'd0) begin failures++; $display("FAIL order_drain: got %0d want 0", f_cnt); end
    endtask

    task automatic test_err_and_async_reset();
        do_reset();
        s_dok = 2'b01;
        @(negedge clk);
        checks++; if (f_dok !== 2'b00) begin failures++; $display("FAIL err_drop: got %b want 00", f_dok); end
        tick();
        s_dok = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (f_err !== 1'b1) begin failures++; $display("FAIL err_sticky[%0d]: got %b want 1", i, f_err); end
            tick();
        end
        m_req = 4'b0001; s_aok = 2'b01;
        tick(); tick();
        #2 resetn = 1'b0;
        model_clear();
        #1;
        checks++; if ({f_cnt, f_err, f_sreq} !== {3'd0, 1'b0, 1'b0}) begin
            failures++; $display("FAIL async_reset: got cnt=%0d err=%b req=%b want 0 0 0", f_cnt, f_err, f_sreq);
        end
        idle_inputs();
    endtask

    task automatic test_random(input int d, input int n);
        int g;
        bit sr;
        logic [3:0] ao, dk;
        do_reset();
        for (int c = 0; c < n; c++) begin
            m_req   = 4'($urandom);
            m_wr    = 4'($urandom);
            m_size  = 8'($urandom);
            m_addr  = {$urandom, $urandom, $urandom, $urandom};
            m_wdata = {$urandom, $urandom, $urandom, $urandom};
            s_aok[d] = 1'($urandom_range(0, 1));
            s_dok[d] = (ocnt[d] > 0) && ($urandom_range(0, 2) == 0);
            s_rdata  = $urandom;
            model_expect(d, g, sr, ao, dk);
            @(negedge clk);
            checks++; if ({o_sreq[d], o_aok[d], o_dok[d]} !== {sr, ao, dk}) begin
                failures++; $display("FAIL rand%0d_hs[%0d]: got req=%b aok=%b dok=%b want %b %b %b", d, c, o_sreq[d], o_aok[d], o_dok[d], sr, ao, dk);
            end
            checks++; if ({o_cnt[d], o_err[d], o_rdata[d]} !== {3'(ocnt[d]), merr[d], s_rdata}) begin
                failures++; $display("FAIL rand%0d_state[%0d]: got cnt=%0d err=%b rdata=%h want %0d %b %h", d, c, o_cnt[d], o_err[d], o_rdata[d], ocnt[d], merr[d], s_rdata);
            end
            if (sr) begin
                checks++; if ({o_saddr[d], o_swdata[d], o_swr[d], o_ssize[d]} !== {m_addr[g*32 +: 32], m_wdata[g*32 +: 32], m_wr[g], m_size[g*2 +: 2]}) begin
                    failures++; $display("FAIL rand%0d_mux[%0d]: got addr=%h master %0d addr=%h", d, c, o_saddr[d], g, m_addr[g*32 +: 32]);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        resetn = 1'b0;
        m_addr = '0; m_wdata = '0; s_rdata = '0;
        idle_inputs();
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_lock();
        test_full();
        test_in_order();
        test_err_and_async_reset();
        test_random(0, 400);
        test_random(1, 400);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sramlike_arbiter.md
Name: sramlike_arbiter

Overview:
N-master to 1-slave arbiter for the SRAM-like (req/addr_ok/data_ok) bus. It is the successor to the fixed dual SRAM ports on the CPU top: inst fetch and data access share one slave port, the number of masters is parametrised, and multiple requests can be in flight. Responses return in order and are routed by an internal owner FIFO. The block sits between the CPU pipeline and the cache/AXI bridge.

Parameters:
N_MASTERS, 2, number of requesting masters (index 0 = data port, highest priority in fixed mode)
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_OUTST, 4, maximum accepted-but-unanswered requests (power of 2, >=2)
ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
m_req  in  N_MASTERS  per-master request
m_wr  in  N_MASTERS  per-master write flag
m_size  in  2*N_MASTERS  per-master size (0 = byte, 1 = half, 2 = word)
m_addr  in  ADDR_W*N_MASTERS  per-master address
m_wdata  in  DATA_W*N_MASTERS  per-master write data
m_addr_ok  out  N_MASTERS  request accepted, one-hot or zero
m_data_ok  out  N_MASTERS  response returned, one-hot or zero
m_rdata  out  DATA_W  read data, broadcast (copy of s_rdata)
s_req  out  1  slave request
s_wr  out  1  muxed write flag
s_size  out  2  muxed size
s_addr  out  ADDR_W  muxed address
s_wdata  out  DATA_W  muxed write data
s_addr_ok  in  1  slave accepted request
s_data_ok  in  1  slave response valid
s_rdata  in  DATA_W  slave read data
outst_cnt  out  clog2(MAX_OUTST+1)  current in-flight count
err  out  1  sticky protocol error

Behaviour:
- Reset (resetn low, async): FSM = IDLE; owner FIFO empty; rr_ptr = 0; outst_cnt = 0; err = 0. While in reset, s_req = 0, m_addr_ok = 0, m_data_ok = 0.
- FSM has two states:
  - IDLE: grant is computed combinationally from m_req. Fixed mode: lowest set index wins. RR mode: first set index at or above rr_ptr, wrapping.
  - IDLE, no accept: if s_req=1 and s_addr_ok=0, the grant is registered and the FSM goes to LOCKED.
  - LOCKED: the registered grant drives the mux. s_req = m_req[grant]. The grant is held until s_addr_ok, then the FSM returns to IDLE. A higher-priority request never preempts a pending handshake.
- s_req = (grant valid) AND (FIFO not full). When the FIFO is full, s_req = 0 and all m_addr_ok = 0.
- m_addr_ok[g] = s_addr_ok & s_req for the granted g only.
- Accept event (s_req & s_addr_ok):
  - push g into the owner FIFO;
  - in RR mode, rr_ptr <= (g+1) mod N_MASTERS (fixed mode leaves rr_ptr unused).
- Response event (s_data_ok):
  - if the FIFO is non-empty, m_data_ok[head] = 1 combinationally and the FIFO pops;
  - if the FIFO is empty, the response is dropped, all m_data_ok = 0, and err <= 1.
- Simultaneous accept and response: push and pop in the same cycle, outst_cnt unchanged. This is legal when full: the pop frees the slot, but s_req is still gated by the registered full flag, so no accept is possible at full.
- data_ok for a request never arrives in the same cycle as its addr_ok. A same-cycle data_ok with the FIFO empty is flagged as err.
- Pointer wrap: FIFO read/write pointers are clog2(MAX_OUTST) bits and wrap naturally. Full/empty are derived from outst_cnt (0 and MAX_OUTST).
- err is cleared only by reset.
- Latency: accept and response routing are both combinational, with zero added cycles. The only registered path is the grant lock.
- Reset mid-operation: all in-flight ownership is discarded. The slave is required to be reset by the same resetn.

Decomposition:
- Shared package: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), ARB_FIXED/ARB_RR constants, FSM state typedef (IDLE/LOCKED).
- One sub-module: sramlike_owner_fifo, parametrised width clog2(N_MASTERS) and depth MAX_OUTST. It provides push/pop/full/empty/count and has async active-low reset.
- Arbitration and the FSM stay in the top.

Test Plan:
- Fixed mode, m_req=2'b11 with s_addr_ok=1 every cycle -> master0 granted every cycle, m_addr_ok=2'b01, master1 starved; data_ok returns on master0 in order.
- RR mode, m_req=2'b11 continuously with s_addr_ok=1 -> grants alternate 0,1,0,1. A 4-master config with m_req=4'b1010 grants 1,3,1,3.
- Master1 requests at addr 0x1fc0_0000 with s_addr_ok held low 3 cycles; master0 raises req in cycle 2 -> s_addr stays 0x1fc0_0000 until accept, master0 granted the following cycle.
- MAX_OUTST=4, 4 accepts with no data_ok -> outst_cnt=4, s_req=0 despite m_req. One data_ok -> next cycle s_req=1, outst_cnt back to 4 after the new accept.
- Interleaved accepts m0,m1,m0 then 3 data_ok with rdata 0x11,0x22,0x33 -> m_data_ok pulses 01,10,01 and m_rdata matches in order.
- s_data_ok with the FIFO empty -> no m_data_ok, err=1 sticky. resetn low asynchronously mid-burst -> outst_cnt=0 and err=0 immediately.
